dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Sequencing controller and two-way arbiter for the single-ported Y86-64 data memory. The pipeline M stage and a testbench/loader port request accesses; the controller selects one, drives the memory array for MEM_LAT cycles, captures read data and returns a completion pulse. It decodes the M-stage icode into read/write/address/data, performs bounds checking, and raises a sticky dmem_error that halts all further grants.

Parameters:
MEM_WORDS, 2048, number of 64-bit words; legal addresses 0..MEM_WORDS-1
MEM_LAT, 2, cycles mem_en is held per access (>=1)
DATA_W, 64, data and address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
m_req  in  1  M-stage request; held with operands until m_done
icode  in  4  M-stage instruction code
valA  in  64  write data (rmmovq/pushq) or read address (popq/ret)
valE  in  64  address for rmmovq/pushq/mrmovq/call
valP  in  64  write data for call
m_done  out  1  one-cycle completion pulse to M stage
m_stall  out  1  M-stage stall request
valM  out  64  read data, updated with m_done, held otherwise
ld_req  in  1  loader request; held until ld_ack
ld_we  in  1  loader write enable
ld_addr  in  64  loader address
ld_wdata  in  64  loader write data
ld_ack  out  1  one-cycle completion pulse to loader
ld_rdata  out  64  loader read data, updated with ld_ack
mem_en  out  1  memory array enable
mem_we  out  1  memory write enable
mem_addr  out  64  memory address
mem_wdata  out  64  memory write data
mem_rdata  in  64  memory read data, valid on the last mem_en cycle
dmem_error  out  1  sticky address error

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; last_grant=LOADER; in-flight access abandoned, no write completes.
- Decode: 4'h4 rmmovq, 4'hA pushq -> write valA to valE; 4'h8 call -> write valP to valE; 4'h5 mrmovq -> read valE; 4'hB popq, 4'h9 ret -> read valA. Any other icode is not a memory op: the request is ignored, no m_done, m_stall=0.
- Pending: pipe_pend = m_req && memop; ld_pend = ld_req.
- m_stall = pipe_pend && !m_done (combinational).
- FSM: IDLE, ACCESS, RESP, HALT.
- IDLE: if exactly one pending, grant it; if both pending, grant the requester that is not last_grant (round-robin). Reset priority: pipeline first. Latch op/addr/wdata at the grant edge G; update last_grant.
- Bounds: if latched addr >= MEM_WORDS -> no mem_en; go to HALT; dmem_error=1; a granted pipeline request gets m_done pulse with valM unchanged; a granted loader request gets ld_ack pulse.
- ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata stable for cycles G..G+MEM_LAT-1; counter counts down from MEM_LAT-1.
- At edge G+MEM_LAT: on reads capture mem_rdata into valM or ld_rdata; go to RESP; m_done or ld_ack = 1 for exactly one cycle.
- RESP -> IDLE at the next edge; a new grant is possible at the edge after that. Throughput: one access per MEM_LAT+2 cycles.
- HALT: absorbing until rst; no grants; m_stall follows pipe_pend, m_done stays 0 after the error pulse.
- Request inputs that change mid-access are ignored; latched values are used.

Optional Feature:
DMEM_ALIGN_CHECK_EN: when defined, a latched address with addr[2:0]!=0 is treated exactly like an out-of-range address (HALT, dmem_error=1, completion pulse, no access). When not defined, alignment is not checked and the address is passed through unchanged.

Test Plan:
- rmmovq icode=4, valE=16, valA=0xDEAD, MEM_LAT=2 -> mem_en/mem_we high 2 cycles, addr=16, wdata=0xDEAD; m_done 1 cycle at G+2; m_stall high until then.
- mrmovq icode=5, valE=16, mem_rdata=0xBEEF -> valM=0xBEEF with m_done; valM holds afterwards.
- m_req and ld_req asserted together after reset, both held -> pipeline served first, loader next; repeat both -> order alternates.
- popq icode=B, valA=2048 -> no mem_en; dmem_error=1, m_done pulse; later ld_req never acked.
- Assert rst during ACCESS of a call -> mem_en drops at once; all outputs 0; next request is granted normally.
- With DMEM_ALIGN_CHECK_EN defined: mrmovq valE=12 -> dmem_error=1, no access. Without it: normal read of addr 12.

Source files
------------

// File: rtl/dmem_ctrl.sv
`default_nettype none
// =============================================================================
// dmem_ctrl : sequencer and round-robin arbiter (M stage vs loader) for the
//             single-ported data memory; sticky dmem_error halts all grants.
//             Optional macro DMEM_ALIGN_CHECK_EN also faults on addr[2:0] != 0.
// Revision  : 1.0
// =============================================================================
module dmem_ctrl #(
    parameter int MEM_WORDS = 2048,
    parameter int MEM_LAT   = 2,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_req,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              m_done,
    output logic              m_stall,
    output logic [DATA_W-1:0] valM,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [DATA_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dmem_error
);

    localparam int                CNT_W        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT     = CNT_W'(MEM_LAT - 1);
    localparam logic [DATA_W-1:0] ADDR_LIMIT   = DATA_W'(MEM_WORDS);
    localparam logic              GRANT_PIPE   = 1'b0;
    localparam logic              GRANT_LOADER = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic               m_done_q, m_done_d;
    logic               ld_ack_q, ld_ack_d;
    logic [DATA_W-1:0]  val_m_q, val_m_d;
    logic [DATA_W-1:0]  ld_rdata_q, ld_rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               dmem_error_q, dmem_error_d;

    logic               pipe_memop, pipe_we;
    logic [DATA_W-1:0]  pipe_addr, pipe_wdata;
    logic               pipe_pend, ld_pend, grant_pipe, grant_ld;
    logic               sel_we, addr_bad;
    logic [DATA_W-1:0]  sel_addr, sel_wdata;

    always_comb begin
        pipe_memop = 1'b0;
        pipe_we    = 1'b0;
        pipe_addr  = valE;
        pipe_wdata = valA;
        case (icode)
            4'h4, 4'hA: begin pipe_memop = 1'b1; pipe_we = 1'b1; end
            4'h8:       begin pipe_memop = 1'b1; pipe_we = 1'b1; pipe_wdata = valP; end
            4'h5:       pipe_memop = 1'b1;
            4'hB, 4'h9: begin pipe_memop = 1'b1; pipe_addr = valA; end
            default:    ;
        endcase
    end

    assign pipe_pend  = m_req & pipe_memop;
    assign ld_pend    = ld_req;
    // Round robin: on contention the side that did not win last time goes next.
    assign grant_pipe = pipe_pend & (~ld_pend | (last_grant_q == GRANT_LOADER));
    assign grant_ld   = ld_pend & ~grant_pipe;
    assign sel_we     = grant_pipe ? pipe_we    : ld_we;
    assign sel_addr   = grant_pipe ? pipe_addr  : ld_addr;
    assign sel_wdata  = grant_pipe ? pipe_wdata : ld_wdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_bad = (sel_addr >= ADDR_LIMIT) || (sel_addr[2:0] != 3'b000);
`else
    assign addr_bad = (sel_addr >= ADDR_LIMIT);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        m_done_d     = 1'b0;
        ld_ack_d     = 1'b0;
        val_m_d      = val_m_q;
        ld_rdata_d   = ld_rdata_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        dmem_error_d = dmem_error_q;
        case (state_q)
            S_IDLE: begin
                if (grant_pipe || grant_ld) begin
                    last_grant_d = grant_ld ? GRANT_LOADER : GRANT_PIPE;
                    owner_d      = grant_ld ? GRANT_LOADER : GRANT_PIPE;
                    if (addr_bad) begin
                        // Faulting access never reaches the array but still completes.
                        state_d      = S_HALT;
                        dmem_error_d = 1'b1;
                        m_done_d     = grant_pipe;
                        ld_ack_d     = grant_ld;
                    end else begin
                        state_d     = S_ACCESS;
                        cnt_d       = CNT_INIT;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q == GRANT_PIPE) begin
                        m_done_d = 1'b1;
                        if (!mem_we_q) val_m_d = mem_rdata;
                    end else begin
                        ld_ack_d = 1'b1;
                        if (!mem_we_q) ld_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GRANT_LOADER;
            owner_q      <= GRANT_PIPE;
            m_done_q     <= 1'b0;
            ld_ack_q     <= 1'b0;
            val_m_q      <= '0;
            ld_rdata_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dmem_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            m_done_q     <= m_done_d;
            ld_ack_q     <= ld_ack_d;
            val_m_q      <= val_m_d;
            ld_rdata_q   <= ld_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            dmem_error_q <= dmem_error_d;
        end
    end

    // Stall is forced low while reset is asserted so every output reads 0.
    assign m_stall    = pipe_pend & ~m_done_q & ~rst;
    assign m_done     = m_done_q;
    assign valM       = val_m_q;
    assign ld_ack     = ld_ack_q;
    assign ld_rdata   = ld_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign dmem_error = dmem_error_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// =============================================================================
// tb_dmem_ctrl : self-checking bench for dmem_ctrl with a transaction-level
//                memory/arbitration reference model.
// Revision     : 1.0
// =============================================================================
module tb_dmem_ctrl;
    localparam int MEM_WORDS = 2048;
    localparam int L         = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req, ld_req, ld_we;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP, ld_addr, ld_wdata;
    logic        m_done, m_stall, ld_ack, mem_en, mem_we, dmem_error;
    logic [63:0] valM, ld_rdata, mem_addr, mem_wdata, mem_rdata;

    dmem_ctrl #(.MEM_WORDS(MEM_WORDS), .MEM_LAT(L), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .icode(icode), .valA(valA),
        .valE(valE), .valP(valP), .m_done(m_done), .m_stall(m_stall),
        .valM(valM), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dmem_error(dmem_error)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input int i);
        return 64'h0123_4567_0000_0000 + 64'(i) * 64'd7919;
    endfunction

    // Physical memory: commits a write only once the full enable window completes.
    bit [63:0]   phys [0:MEM_WORDS-1];
    bit          written [0:MEM_WORDS-1];
    int          en_run;
    logic [10:0] mem_idx;
    assign mem_idx   = mem_addr[10:0];
    assign mem_rdata = !mem_en ? 64'd0 : (written[mem_idx] ? phys[mem_idx] : init_val(int'(mem_idx)));

    always @(posedge clk) begin
        if (rst || !mem_en) en_run <= 0;
        else begin
            if (en_run == L - 1 && mem_we) begin
                phys[mem_idx]    <= mem_wdata;
                written[mem_idx] <= 1'b1;
            end
            en_run <= en_run + 1;
        end
    end

    int          n_assert = 0, n_fail = 0;
    int          ref_last = 1;           // 0 = pipeline won last, 1 = loader
    logic [63:0] ref_mem [0:MEM_WORDS-1];
    logic [63:0] exp_valm = 64'd0, exp_ldr = 64'd0;
    logic [3:0]  ops [6] = '{4'h4, 4'hA, 4'h8, 4'h5, 4'hB, 4'h9};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic decode(input logic [3:0] ic, input logic [63:0] va, ve, vp,
                          output bit is_mem, output bit we, output logic [63:0] a, wd);
        is_mem = 1'b1; we = 1'b0; a = ve; wd = va;
        case (ic)
            4'h4, 4'hA: we = 1'b1;
            4'h8:       begin we = 1'b1; wd = vp; end
            4'h5:       ;
            4'hB, 4'h9: a = va;
            default:    is_mem = 1'b0;
        endcase
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);     chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0); chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_m_done"}, m_done, 0);     chk({tag, "_ld_ack"}, ld_ack, 0);
        chk({tag, "_valM"}, valM, 0);         chk({tag, "_ld_rdata"}, ld_rdata, 0);
        chk({tag, "_dmem_error"}, dmem_error, 0); chk({tag, "_m_stall"}, m_stall, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        m_req = 0; ld_req = 0; rst = 1;
        #1 chk_zero_outputs("reset");
        @(negedge clk);
        rst = 0;
        exp_valm = 0; exp_ldr = 0; ref_last = 1;
    endtask

    // One arbitration round: optional pipeline op and optional loader op issued together.
    task automatic run(input bit dp, input logic [3:0] ic, input logic [63:0] va, ve, vp,
                       input bit dl, input bit lwe, input logic [63:0] la, lwd);
        bit p_mem, p_we, pp, p_done, l_done, p_fin, l_fin, exp_en;
        logic [63:0] p_a, p_wd, ea, ewd;
        int p_slot, l_slot, n, last, act, g;
        bit ewe;
        decode(ic, va, ve, vp, p_mem, p_we, p_a, p_wd);
        pp = dp && p_mem;
        p_slot = -1; l_slot = -1; p_fin = 0; l_fin = 0;
        if (pp && dl) begin
            if (ref_last == 1) begin p_slot = 0; l_slot = 1; end
            else begin l_slot = 0; p_slot = 1; end
        end else begin
            if (pp) p_slot = 0;
            if (dl) l_slot = 0;
        end
        n = (pp ? 1 : 0) + (dl ? 1 : 0);
        last = (n == 0) ? 4 : 1 + (n - 1) * (L + 2) + L;
        @(negedge clk);
        m_req = dp; icode = ic; valA = va; valE = ve; valP = vp;
        ld_req = dl; ld_we = lwe; ld_addr = la; ld_wdata = lwd;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            act = -1;
            for (int s = 0; s < n; s++) begin
                g = 1 + s * (L + 2);
                if (c >= g && c <= g + L - 1) act = s;
            end
            exp_en = (act >= 0);
            chk("mem_en", mem_en, exp_en);
            if (exp_en) begin
                if (act == p_slot) begin ea = p_a; ewe = p_we; ewd = p_wd; end
                else begin ea = la; ewe = lwe; ewd = lwd; end
                chk("mem_addr", mem_addr, ea);
                chk("mem_we", mem_we, ewe);
                if (ewe) chk("mem_wdata", mem_wdata, ewd);
            end
            p_done = (p_slot >= 0) && (c == 1 + p_slot * (L + 2) + L);
            l_done = (l_slot >= 0) && (c == 1 + l_slot * (L + 2) + L);
            if (p_done && !p_we) exp_valm = ref_mem[p_a[10:0]];
            if (l_done && !lwe)  exp_ldr  = ref_mem[la[10:0]];
            chk("m_done", m_done, p_done);
            chk("ld_ack", ld_ack, l_done);
            chk("m_stall", m_stall, pp && !p_done && !p_fin);
            chk("valM", valM, exp_valm);
            chk("ld_rdata", ld_rdata, exp_ldr);
            chk("dmem_error", dmem_error, 0);
            if (p_done) begin
                if (p_we) ref_mem[p_a[10:0]] = p_wd;
                ref_last = 0; p_fin = 1; m_req = 0;
            end
            if (l_done) begin
                if (lwe) ref_mem[la[10:0]] = lwd;
                ref_last = 1; l_fin = 1; ld_req = 0;
            end
        end
        m_req = 0; ld_req = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] a, d, la, ld;
        int          sel;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
        rst = 1; m_req = 0; ld_req = 0; ld_we = 0; icode = 0;
        valA = 0; valE = 0; valP = 0; ld_addr = 0; ld_wdata = 0;
        #1 chk_zero_outputs("por");
        @(negedge clk); rst = 0;

        // Directed: write, read-back, loader write then pipeline read.
        run(1, 4'h4, 64'hDEAD, 64'd16, 64'd0, 0, 0, 0, 0);
        run(1, 4'h5, 64'd0, 64'd16, 64'd0, 0, 0, 0, 0);
        run(0, 4'h0, 0, 0, 0, 1, 1, 64'd24, 64'hBEEF);
        run(1, 4'h5, 64'd0, 64'd24, 64'd0, 0, 0, 0, 0);
        run(0, 4'h0, 0, 0, 0, 1, 0, 64'd16, 0);
        // Contention: pipeline wins after loader, then loader wins after pipeline.
        run(1, 4'hA, 64'h1111, 64'd32, 64'd0, 1, 0, 64'd32, 0);
        run(1, 4'h8, 64'd0, 64'd40, 64'h2222, 0, 0, 0, 0);
        run(1, 4'hB, 64'd40, 64'd0, 64'd0, 1, 1, 64'd40, 64'h3333);
        // Non-memory icode is ignored entirely.
        run(1, 4'h6, 64'd8, 64'd8, 64'd8, 0, 0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            ic  = ops[$urandom_range(0, 5)];
            a   = 64'($urandom_range(0, 15)) * 64'd8;
            d   = {$urandom, $urandom};
            la  = 64'($urandom_range(0, 15)) * 64'd8;
            ld  = {$urandom, $urandom};
            sel = $urandom_range(0, 2);
            run(sel != 1, ic, (ic == 4'hB || ic == 4'h9) ? a : d, a, d,
                sel != 0, 1'($urandom_range(0, 1)), la, ld);
        end

        // Reset during the access window of a call: no write may land.
        @(negedge clk);
        m_req = 1; icode = 4'h8; valE = 64'd48; valP = 64'hCAFE;
        @(posedge clk); #1;
        chk("call_mem_en", mem_en, 1);
        chk("call_mem_we", mem_we, 1);
        #2 rst = 1;
        #1 chk_zero_outputs("midrst");
        @(negedge clk); m_req = 0;
        @(negedge clk); rst = 0;
        exp_valm = 0; exp_ldr = 0; ref_last = 1;
        run(0, 4'h0, 0, 0, 0, 1, 0, 64'd48, 0);
        run(1, 4'h9, 64'd48, 64'd0, 64'd0, 1, 0, 64'd16, 0);

`ifdef DMEM_ALIGN_CHECK_EN
        @(negedge clk);
        m_req = 1; icode = 4'h5; valE = 64'd12;
        @(posedge clk); #1;
        chk("align_err", dmem_error, 1);
        chk("align_done", m_done, 1);
        chk("align_mem_en", mem_en, 0);
        do_reset();
`else
        run(1, 4'h5, 64'd0, 64'd12, 64'd0, 0, 0, 0, 0);
`endif

        // Out-of-range popq: completion pulse, sticky error, no further grants.
        @(negedge clk);
        m_req = 1; icode = 4'hB; valA = 64'd2048;
        @(posedge clk); #1;
        chk("oob_done", m_done, 1);
        chk("oob_err", dmem_error, 1);
        chk("oob_mem_en", mem_en, 0);
        chk("oob_valM", valM, exp_valm);
        chk("oob_stall", m_stall, 0);
        ld_req = 1; ld_we = 0; ld_addr = 64'd16;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("halt_done", m_done, 0);
            chk("halt_ack", ld_ack, 0);
            chk("halt_mem_en", mem_en, 0);
            chk("halt_stall", m_stall, 1);
            chk("halt_err", dmem_error, 1);
        end
        do_reset();
        run(1, 4'h5, 64'd0, 64'd16, 64'd0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
